// File: rtl/arith_logic_unit_pkg.sv
// Shared constants for the integer core: widths and the internal opcode map.
// The decoder, reservation station and ROB import the same definitions.
package arith_logic_unit_pkg;

    localparam int unsigned DAT_W   = 32;
    localparam int unsigned ROB_BIT = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_BIT = 5;

    localparam logic [OP_W-1:0] OP_LUI   = 6'd0;
    localparam logic [OP_W-1:0] OP_AUIPC = 6'd1;
    localparam logic [OP_W-1:0] OP_JAL   = 6'd2;
    localparam logic [OP_W-1:0] OP_JALR  = 6'd3;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
    localparam logic [OP_W-1:0] OP_BLT   = 6'd6;
    localparam logic [OP_W-1:0] OP_BGE   = 6'd7;
    localparam logic [OP_W-1:0] OP_BLTU  = 6'd8;
    localparam logic [OP_W-1:0] OP_BGEU  = 6'd9;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd18;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd19;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'd20;
    localparam logic [OP_W-1:0] OP_XORI  = 6'd21;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd22;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd23;
    localparam logic [OP_W-1:0] OP_SLLI  = 6'd24;
    localparam logic [OP_W-1:0] OP_SRLI  = 6'd25;
    localparam logic [OP_W-1:0] OP_SRAI  = 6'd26;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd27;
    localparam logic [OP_W-1:0] OP_SUB   = 6'd28;
    localparam logic [OP_W-1:0] OP_SLL   = 6'd29;
    localparam logic [OP_W-1:0] OP_SLT   = 6'd30;
    localparam logic [OP_W-1:0] OP_SLTU  = 6'd31;
    localparam logic [OP_W-1:0] OP_XOR   = 6'd32;
    localparam logic [OP_W-1:0] OP_SRL   = 6'd33;
    localparam logic [OP_W-1:0] OP_SRA   = 6'd34;
    localparam logic [OP_W-1:0] OP_OR    = 6'd35;
    localparam logic [OP_W-1:0] OP_AND   = 6'd36;

    typedef struct packed {
        logic               en;
        logic [ROB_BIT-1:0] q;
        logic [DAT_W-1:0]   v;
        logic               cbr;
        logic [DAT_W-1:0]   cbt;
    } cdb_t;

endpackage

// File: rtl/alu_compute.sv
// Combinational datapath: result value, taken flag and next PC for one issued op.
module alu_compute
    import arith_logic_unit_pkg::*;
(
    input  logic [OP_W-1:0]  op_i,
    input  logic             ic_i,
    input  logic [DAT_W-1:0] vs_i,
    input  logic [DAT_W-1:0] vt_i,
    input  logic [DAT_W-1:0] imm_i,
    input  logic [DAT_W-1:0] pc_i,
    output logic [DAT_W-1:0] v_o,
    output logic             cbr_o,
    output logic [DAT_W-1:0] cbt_o
);

    logic [DAT_W-1:0] w_seq;
    logic [DAT_W-1:0] w_pc_imm;
    logic [DAT_W-1:0] w_b;
    logic [4:0]       w_shamt;
    logic             w_eq;
    logic             w_lt;
    logic             w_ltu;
    logic             w_take;

    assign w_seq    = pc_i + (ic_i ? DAT_W'(2) : DAT_W'(4));
    assign w_pc_imm = pc_i + imm_i;
    // Register-form ops occupy the top of the opcode map; branches also compare vs/vt.
    assign w_b      = (op_i >= OP_ADD || (op_i >= OP_BEQ && op_i <= OP_BGEU)) ? vt_i : imm_i;
    assign w_shamt  = w_b[4:0];
    assign w_eq     = (vs_i == w_b);
    assign w_lt     = ($signed(vs_i) < $signed(w_b));
    assign w_ltu    = (vs_i < w_b);

    always_comb begin
        w_take = 1'b0;
        case (op_i)
            OP_BEQ:  w_take = w_eq;
            OP_BNE:  w_take = !w_eq;
            OP_BLT:  w_take = w_lt;
            OP_BGE:  w_take = !w_lt;
            OP_BLTU: w_take = w_ltu;
            OP_BGEU: w_take = !w_ltu;
            default: w_take = 1'b0;
        endcase
    end

    always_comb begin
        v_o   = '0;
        cbr_o = 1'b0;
        cbt_o = w_seq;
        case (op_i)
            OP_LUI:   v_o = imm_i;
            OP_AUIPC: v_o = w_pc_imm;
            OP_JAL: begin
                v_o   = w_seq;
                cbr_o = 1'b1;
                cbt_o = w_pc_imm;
            end
            OP_JALR: begin
                v_o   = w_seq;
                cbr_o = 1'b1;
                cbt_o = (vs_i + imm_i) & ~DAT_W'(1);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                cbr_o = w_take;
                cbt_o = w_take ? w_pc_imm : w_seq;
            end
            OP_ADDI, OP_ADD:  v_o = vs_i + w_b;
            OP_SUB:           v_o = vs_i - w_b;
            OP_SLTI, OP_SLT:  v_o = {{(DAT_W-1){1'b0}}, w_lt};
            OP_SLTIU, OP_SLTU: v_o = {{(DAT_W-1){1'b0}}, w_ltu};
            OP_XORI, OP_XOR:  v_o = vs_i ^ w_b;
            OP_ORI, OP_OR:    v_o = vs_i | w_b;
            OP_ANDI, OP_AND:  v_o = vs_i & w_b;
            OP_SLLI, OP_SLL:  v_o = vs_i << w_shamt;
            OP_SRLI, OP_SRL:  v_o = vs_i >> w_shamt;
            OP_SRAI, OP_SRA:  v_o = $unsigned($signed(vs_i) >>> w_shamt);
            default:          v_o = '0;
        endcase
    end

endmodule

// File: rtl/arith_logic_unit.sv
// Single-cycle integer execution unit; registers the ALU result onto the CDB.
module arith_logic_unit
    import arith_logic_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               rs_en_i,
    input  logic [OP_W-1:0]    rs_op_i,
    input  logic               rs_ic_i,
    input  logic [ROB_BIT-1:0] rs_qd_i,
    input  logic [DAT_W-1:0]   rs_vs_i,
    input  logic [DAT_W-1:0]   rs_vt_i,
    input  logic [DAT_W-1:0]   rs_imm_i,
    input  logic [DAT_W-1:0]   rs_pc_i,
    output logic               cdb_en_o,
    output logic [ROB_BIT-1:0] cdb_q_o,
    output logic [DAT_W-1:0]   cdb_v_o,
    output logic               cdb_cbr_o,
    output logic [DAT_W-1:0]   cdb_cbt_o
);

    logic [DAT_W-1:0] w_v;
    logic             w_cbr;
    logic [DAT_W-1:0] w_cbt;
    cdb_t             r_cdb;

    alu_compute u_alu_compute (
        .op_i  (rs_op_i),
        .ic_i  (rs_ic_i),
        .vs_i  (rs_vs_i),
        .vt_i  (rs_vt_i),
        .imm_i (rs_imm_i),
        .pc_i  (rs_pc_i),
        .v_o   (w_v),
        .cbr_o (w_cbr),
        .cbt_o (w_cbt)
    );

    // Data fields only load on a real issue; an idle cycle just drops the valid bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cdb <= '0;
        end else if (en) begin
            r_cdb.en <= rs_en_i;
            if (rs_en_i) begin
                r_cdb.q   <= rs_qd_i;
                r_cdb.v   <= w_v;
                r_cdb.cbr <= w_cbr;
                r_cdb.cbt <= w_cbt;
            end
        end
    end

    assign cdb_en_o  = r_cdb.en;
    assign cdb_q_o   = r_cdb.q;
    assign cdb_v_o   = r_cdb.v;
    assign cdb_cbr_o = r_cdb.cbr;
    assign cdb_cbt_o = r_cdb.cbt;

endmodule

// File: tb/tb_arith_logic_unit.sv
// Directed-vector bench for arith_logic_unit with hand-computed expectations.
module tb_arith_logic_unit;
    import arith_logic_unit_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               rs_en_i;
    logic [OP_W-1:0]    rs_op_i;
    logic               rs_ic_i;
    logic [ROB_BIT-1:0] rs_qd_i;
    logic [DAT_W-1:0]   rs_vs_i;
    logic [DAT_W-1:0]   rs_vt_i;
    logic [DAT_W-1:0]   rs_imm_i;
    logic [DAT_W-1:0]   rs_pc_i;
    logic               cdb_en_o;
    logic [ROB_BIT-1:0] cdb_q_o;
    logic [DAT_W-1:0]   cdb_v_o;
    logic               cdb_cbr_o;
    logic [DAT_W-1:0]   cdb_cbt_o;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    arith_logic_unit u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rs_en_i   (rs_en_i),
        .rs_op_i   (rs_op_i),
        .rs_ic_i   (rs_ic_i),
        .rs_qd_i   (rs_qd_i),
        .rs_vs_i   (rs_vs_i),
        .rs_vt_i   (rs_vt_i),
        .rs_imm_i  (rs_imm_i),
        .rs_pc_i   (rs_pc_i),
        .cdb_en_o  (cdb_en_o),
        .cdb_q_o   (cdb_q_o),
        .cdb_v_o   (cdb_v_o),
        .cdb_cbr_o (cdb_cbr_o),
        .cdb_cbt_o (cdb_cbt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [OP_W-1:0] op, input logic ic, input logic [3:0] qd,
                         input logic [31:0] vs, input logic [31:0] vt, input logic [31:0] imm,
                         input logic [31:0] pc);
        rs_en_i  = 1'b1;
        rs_op_i  = op;
        rs_ic_i  = ic;
        rs_qd_i  = qd;
        rs_vs_i  = vs;
        rs_vt_i  = vt;
        rs_imm_i = imm;
        rs_pc_i  = pc;
    endtask

    task automatic check_out(input string tag, input logic exp_en, input logic [3:0] exp_q,
                             input logic [31:0] exp_v, input logic exp_cbr,
                             input logic [31:0] exp_cbt);
        check_eq({tag, ".en"},  32'(cdb_en_o),  32'(exp_en));
        check_eq({tag, ".q"},   32'(cdb_q_o),   32'(exp_q));
        check_eq({tag, ".v"},   cdb_v_o,        exp_v);
        check_eq({tag, ".cbr"}, 32'(cdb_cbr_o), 32'(exp_cbr));
        check_eq({tag, ".cbt"}, cdb_cbt_o,      exp_cbt);
    endtask

    task automatic run_op(input string tag, input logic [OP_W-1:0] op, input logic ic,
                          input logic [3:0] qd, input logic [31:0] vs, input logic [31:0] vt,
                          input logic [31:0] imm, input logic [31:0] pc,
                          input logic [31:0] exp_v, input logic exp_cbr,
                          input logic [31:0] exp_cbt);
        drive(op, ic, qd, vs, vt, imm, pc);
        step();
        check_out(tag, 1'b1, qd, exp_v, exp_cbr, exp_cbt);
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        drive(OP_ADD, 1'b0, 4'd9, 32'h1, 32'h1, 32'h0, 32'h10);
        step();
        step();
        check_out("reset", 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);

        rst = 1'b1;
        run_op("add",   OP_ADD,   1'b0, 4'd5, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h200,
               32'h80000000, 1'b0, 32'h204);
        run_op("srai",  OP_SRAI,  1'b0, 4'd6, 32'h80000000, 32'h0, 32'h21, 32'h0,
               32'hC0000000, 1'b0, 32'h4);
        run_op("sltu",  OP_SLTU,  1'b0, 4'd7, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h8,
               32'h1, 1'b0, 32'hC);
        run_op("slt",   OP_SLT,   1'b0, 4'd8, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h8,
               32'h0, 1'b0, 32'hC);
        run_op("blt",   OP_BLT,   1'b0, 4'd1, 32'hFFFFFFFF, 32'h0, 32'h20, 32'h100,
               32'h0, 1'b1, 32'h120);
        run_op("bltu",  OP_BLTU,  1'b0, 4'd2, 32'hFFFFFFFF, 32'h0, 32'h20, 32'h100,
               32'h0, 1'b0, 32'h104);
        run_op("jalr",  OP_JALR,  1'b1, 4'd3, 32'h1003, 32'h0, 32'h2, 32'h40,
               32'h42, 1'b1, 32'h1004);
        run_op("jal",   OP_JAL,   1'b1, 4'd4, 32'h0, 32'h0, 32'hFFFFFF00, 32'h300,
               32'h302, 1'b1, 32'h200);
        run_op("bge",   OP_BGE,   1'b1, 4'd10, 32'h5, 32'h5, 32'h8, 32'h10,
               32'h0, 1'b1, 32'h18);
        run_op("bne",   OP_BNE,   1'b0, 4'd11, 32'h5, 32'h5, 32'h8, 32'h10,
               32'h0, 1'b0, 32'h14);
        run_op("sub",   OP_SUB,   1'b0, 4'd12, 32'h0, 32'h1, 32'h0, 32'h0,
               32'hFFFFFFFF, 1'b0, 32'h4);
        run_op("lui",   OP_LUI,   1'b0, 4'd13, 32'h0, 32'h0, 32'hABCDE000, 32'h0,
               32'hABCDE000, 1'b0, 32'h4);
        run_op("auipc", OP_AUIPC, 1'b0, 4'd14, 32'h0, 32'h0, 32'hFFFFF000, 32'h1000,
               32'h0, 1'b0, 32'h1004);
        run_op("sll",   OP_SLL,   1'b0, 4'd15, 32'h1, 32'h3F, 32'h0, 32'h0,
               32'h80000000, 1'b0, 32'h4);
        run_op("srl",   OP_SRL,   1'b0, 4'd0, 32'h80000000, 32'h4, 32'h0, 32'h0,
               32'h08000000, 1'b0, 32'h4);
        run_op("addi",  OP_ADDI,  1'b1, 4'd1, 32'hA, 32'h0, 32'hFFFFFFFD, 32'hFFFFFFFE,
               32'h7, 1'b0, 32'h0);
        run_op("andi",  OP_ANDI,  1'b0, 4'd2, 32'hFF00FF00, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h0,
               32'h0F000F00, 1'b0, 32'h4);
        run_op("rsvd",  6'd12,    1'b1, 4'd3, 32'h1234, 32'h5678, 32'h9, 32'h500,
               32'h0, 1'b0, 32'h502);

        // Back-to-back issue then a two-cycle stall with a pending op on the inputs.
        run_op("xor",   OP_XOR,   1'b0, 4'd1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h60,
               32'hFF00FF00, 1'b0, 32'h64);
        run_op("or",    OP_OR,    1'b0, 4'd2, 32'h12340000, 32'h00005678, 32'h0, 32'h64,
               32'h12345678, 1'b0, 32'h68);
        en = 1'b0;
        drive(OP_JAL, 1'b0, 4'd3, 32'h0, 32'h0, 32'h40, 32'h80);
        step();
        check_out("hold1", 1'b1, 4'd2, 32'h12345678, 1'b0, 32'h68);
        step();
        check_out("hold2", 1'b1, 4'd2, 32'h12345678, 1'b0, 32'h68);

        en = 1'b1;
        rs_en_i = 1'b0;
        step();
        check_eq("idle.en", 32'(cdb_en_o), 32'h0);

        // Reset wins over a same-cycle issue.
        drive(OP_ADD, 1'b0, 4'd9, 32'h3, 32'h4, 32'h0, 32'h700);
        rst = 1'b0;
        step();
        check_out("rst_issue", 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        rs_en_i = 1'b0;
        step();
        check_eq("post_rst.en", 32'(cdb_en_o), 32'h0);
        step();
        check_eq("post_rst2.en", 32'(cdb_en_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
